// File: rtl/pair_cfg_loader_pkg.sv
// Shared types, frame layout constants and loader FSM states for pair_cfg_loader.
package pair_cfg_loader_pkg;

  typedef logic [31:0] int32_t;
  typedef logic [1:0]  int2_t;
  typedef logic        bool;

  localparam int CFG_WORDS = 23;
  localparam int WIDX_SEL1 = 20;
  localparam int WIDX_SEL2 = 21;
  localparam int WIDX_LAST = 22;

  localparam int N_CONS  = 20;
  localparam int N_SEL1  = 12;
  localparam int N_SEL2  = 24;
  localparam int N_REL   = 4;
  localparam int N_ARITH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PEND
  } state_t;

endpackage

// File: rtl/pair_cfg_unpack.sv
// Combinational unpacking of a 23-word config store into constants, selects and ops.
module pair_cfg_unpack
  import pair_cfg_loader_pkg::*;
(
  input  int32_t i_words [CFG_WORDS],
  output int32_t o_cons  [N_CONS],
  output bool    o_sel1  [N_SEL1],
  output int2_t  o_sel2  [N_SEL2],
  output int2_t  o_rel   [N_REL],
  output bool    o_arith [N_ARITH]
);

  // Word 20 only carries 12 select bits; the upper bits are deliberately dropped.
  logic w_unused;
  assign w_unused = ^i_words[WIDX_SEL1][31:12];

  always_comb begin
    for (int i = 0; i < N_CONS; i++) o_cons[i] = i_words[i];
    for (int i = 0; i < N_SEL1; i++) o_sel1[i] = i_words[WIDX_SEL1][i];
    for (int i = 0; i < 16; i++) o_sel2[i] = i_words[WIDX_SEL2][2*i +: 2];
    for (int i = 0; i < 8; i++) o_sel2[16+i] = i_words[WIDX_LAST][2*i +: 2];
    for (int i = 0; i < N_REL; i++) o_rel[i] = i_words[WIDX_LAST][16+2*i +: 2];
    for (int i = 0; i < N_ARITH; i++) o_arith[i] = i_words[WIDX_LAST][24+i];
  end

endmodule

// File: rtl/pair_cfg_loader.sv
// Double-buffered config loader: 23-word frames fill a shadow store, swapped in when the atom is idle.
// Optional readback port enabled by defining PAIR_CFG_READBACK_EN.
module pair_cfg_loader
  import pair_cfg_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i__cfg_valid,
  output logic        o__cfg_ready,
  input  logic [31:0] i__cfg_data,
  input  logic        i__cfg_last,
  input  logic        i__pkt_idle,
`ifdef PAIR_CFG_READBACK_EN
  input  logic [4:0]  i__rd_idx,
  output logic [31:0] o__rd_data,
`endif
  output logic [31:0] o__cons_1,
  output logic [31:0] o__cons_2,
  output logic [31:0] o__cons_3,
  output logic [31:0] o__cons_4,
  output logic [31:0] o__cons_5,
  output logic [31:0] o__cons_6,
  output logic [31:0] o__cons_7,
  output logic [31:0] o__cons_8,
  output logic [31:0] o__cons_9,
  output logic [31:0] o__cons_10,
  output logic [31:0] o__cons_11,
  output logic [31:0] o__cons_12,
  output logic [31:0] o__cons_13,
  output logic [31:0] o__cons_14,
  output logic [31:0] o__cons_15,
  output logic [31:0] o__cons_16,
  output logic [31:0] o__cons_17,
  output logic [31:0] o__cons_18,
  output logic [31:0] o__cons_19,
  output logic [31:0] o__cons_20,
  output logic        o__sel_1,
  output logic [1:0]  o__sel_2,
  output logic [1:0]  o__sel_3,
  output logic        o__sel_4,
  output logic [1:0]  o__sel_5,
  output logic [1:0]  o__sel_6,
  output logic        o__sel_7,
  output logic [1:0]  o__sel_8,
  output logic [1:0]  o__sel_9,
  output logic        o__sel_10,
  output logic [1:0]  o__sel_11,
  output logic [1:0]  o__sel_12,
  output logic        o__sel_13,
  output logic [1:0]  o__sel_14,
  output logic [1:0]  o__sel_15,
  output logic        o__sel_16,
  output logic [1:0]  o__sel_17,
  output logic [1:0]  o__sel_18,
  output logic        o__sel_19,
  output logic [1:0]  o__sel_20,
  output logic [1:0]  o__sel_21,
  output logic        o__sel_22,
  output logic [1:0]  o__sel_23,
  output logic [1:0]  o__sel_24,
  output logic        o__sel_25,
  output logic [1:0]  o__sel_26,
  output logic [1:0]  o__sel_27,
  output logic        o__sel_28,
  output logic [1:0]  o__sel_29,
  output logic [1:0]  o__sel_30,
  output logic        o__sel_31,
  output logic [1:0]  o__sel_32,
  output logic [1:0]  o__sel_33,
  output logic        o__sel_34,
  output logic [1:0]  o__sel_35,
  output logic [1:0]  o__sel_36,
  output logic [1:0]  o__rel_op1,
  output logic [1:0]  o__rel_op2,
  output logic [1:0]  o__rel_op3,
  output logic [1:0]  o__rel_op4,
  output logic        o__arith_op1,
  output logic        o__arith_op2,
  output logic        o__arith_op3,
  output logic        o__arith_op4,
  output logic        o__arith_op5,
  output logic        o__arith_op6,
  output logic        o__arith_op7,
  output logic        o__arith_op8,
  output logic        o__swap,
  output logic        o__cfg_err,
  output logic [7:0]  o__cfg_gen
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t          r_state, w_next;
  logic [4:0]      r_idx;
  logic [TO_W-1:0] r_toCnt;
  int32_t          r_shadow [CFG_WORDS];
  int32_t          r_active [CFG_WORDS];
  logic            r_swap, r_err;
  logic [7:0]      r_gen;

  logic w_accept, w_abort, w_frameDone, w_commit;

  assign o__cfg_ready = (r_state != ST_PEND);
  assign w_accept     = i__cfg_valid & o__cfg_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // A frame must end exactly on word 22 with last set; anything else, or a stall, aborts it.
  always_comb begin
    w_next      = r_state;
    w_abort     = 1'b0;
    w_frameDone = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (i__cfg_last) w_abort = 1'b1;
          else             w_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          if (r_idx == 5'(WIDX_LAST)) begin
            if (i__cfg_last) begin
              w_frameDone = 1'b1;
              w_next      = ST_PEND;
            end else begin
              w_abort = 1'b1;
              w_next  = ST_IDLE;
            end
          end else if (i__cfg_last) begin
            w_abort = 1'b1;
            w_next  = ST_IDLE;
          end
        end else if (r_toCnt == TO_W'(TIMEOUT_CYC - 1)) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (i__pkt_idle) begin
          w_commit = 1'b1;
          w_next   = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_toCnt <= '0;
      r_swap  <= 1'b0;
      r_err   <= 1'b0;
      r_gen   <= '0;
      for (int i = 0; i < CFG_WORDS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_swap <= w_commit;
      r_err  <= w_abort;
      if (w_accept) r_shadow[r_idx] <= i__cfg_data;
      if (w_abort || w_frameDone) r_idx <= '0;
      else if (w_accept)          r_idx <= r_idx + 5'd1;
      if (r_state == ST_LOAD && !w_accept && !w_abort) r_toCnt <= r_toCnt + 1'b1;
      else                                              r_toCnt <= '0;
      if (w_commit) begin
        r_active <= r_shadow;
        r_gen    <= r_gen + 8'd1;
      end
    end
  end

`ifdef PAIR_CFG_READBACK_EN
  logic [31:0] r_rdData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_rdData <= '0;
    else if (i__rd_idx == 5'(WIDX_SEL1))      r_rdData <= {20'd0, r_active[WIDX_SEL1][11:0]};
    else if (i__rd_idx <= 5'(WIDX_LAST))      r_rdData <= r_active[i__rd_idx];
    else                                      r_rdData <= '0;
  end

  assign o__rd_data = r_rdData;
`endif

  int32_t w_cons  [N_CONS];
  bool    w_sel1  [N_SEL1];
  int2_t  w_sel2  [N_SEL2];
  int2_t  w_rel   [N_REL];
  bool    w_arith [N_ARITH];

  pair_cfg_unpack u_unpack (
    .i_words (r_active),
    .o_cons  (w_cons),
    .o_sel1  (w_sel1),
    .o_sel2  (w_sel2),
    .o_rel   (w_rel),
    .o_arith (w_arith)
  );

  assign o__cons_1  = w_cons[0];
  assign o__cons_2  = w_cons[1];
  assign o__cons_3  = w_cons[2];
  assign o__cons_4  = w_cons[3];
  assign o__cons_5  = w_cons[4];
  assign o__cons_6  = w_cons[5];
  assign o__cons_7  = w_cons[6];
  assign o__cons_8  = w_cons[7];
  assign o__cons_9  = w_cons[8];
  assign o__cons_10 = w_cons[9];
  assign o__cons_11 = w_cons[10];
  assign o__cons_12 = w_cons[11];
  assign o__cons_13 = w_cons[12];
  assign o__cons_14 = w_cons[13];
  assign o__cons_15 = w_cons[14];
  assign o__cons_16 = w_cons[15];
  assign o__cons_17 = w_cons[16];
  assign o__cons_18 = w_cons[17];
  assign o__cons_19 = w_cons[18];
  assign o__cons_20 = w_cons[19];

  // Every third select (1,4,...,34) is 1 bit wide; the rest are 2-bit, in ascending order.
  assign o__sel_1  = w_sel1[0];
  assign o__sel_2  = w_sel2[0];
  assign o__sel_3  = w_sel2[1];
  assign o__sel_4  = w_sel1[1];
  assign o__sel_5  = w_sel2[2];
  assign o__sel_6  = w_sel2[3];
  assign o__sel_7  = w_sel1[2];
  assign o__sel_8  = w_sel2[4];
  assign o__sel_9  = w_sel2[5];
  assign o__sel_10 = w_sel1[3];
  assign o__sel_11 = w_sel2[6];
  assign o__sel_12 = w_sel2[7];
  assign o__sel_13 = w_sel1[4];
  assign o__sel_14 = w_sel2[8];
  assign o__sel_15 = w_sel2[9];
  assign o__sel_16 = w_sel1[5];
  assign o__sel_17 = w_sel2[10];
  assign o__sel_18 = w_sel2[11];
  assign o__sel_19 = w_sel1[6];
  assign o__sel_20 = w_sel2[12];
  assign o__sel_21 = w_sel2[13];
  assign o__sel_22 = w_sel1[7];
  assign o__sel_23 = w_sel2[14];
  assign o__sel_24 = w_sel2[15];
  assign o__sel_25 = w_sel1[8];
  assign o__sel_26 = w_sel2[16];
  assign o__sel_27 = w_sel2[17];
  assign o__sel_28 = w_sel1[9];
  assign o__sel_29 = w_sel2[18];
  assign o__sel_30 = w_sel2[19];
  assign o__sel_31 = w_sel1[10];
  assign o__sel_32 = w_sel2[20];
  assign o__sel_33 = w_sel2[21];
  assign o__sel_34 = w_sel1[11];
  assign o__sel_35 = w_sel2[22];
  assign o__sel_36 = w_sel2[23];

  assign o__rel_op1 = w_rel[0];
  assign o__rel_op2 = w_rel[1];
  assign o__rel_op3 = w_rel[2];
  assign o__rel_op4 = w_rel[3];

  assign o__arith_op1 = w_arith[0];
  assign o__arith_op2 = w_arith[1];
  assign o__arith_op3 = w_arith[2];
  assign o__arith_op4 = w_arith[3];
  assign o__arith_op5 = w_arith[4];
  assign o__arith_op6 = w_arith[5];
  assign o__arith_op7 = w_arith[6];
  assign o__arith_op8 = w_arith[7];

  assign o__swap    = r_swap;
  assign o__cfg_err = r_err;
  assign o__cfg_gen = r_gen;

endmodule
